// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate test sequencer.
//   state_e        : sequencer FSM states
//   AND .. XNOR    : bit positions of each gate result inside the 7-bit res_i word
//   VEC_COUNT      : number of {a,b} input vectors exercised per pass
//   RES_W          : width of the gate result word
package gate_test_pkg;

  localparam int unsigned VEC_COUNT = 4;
  localparam int unsigned RES_W     = 7;

  // res_i / golden bit positions
  localparam int unsigned AND  = 0;
  localparam int unsigned OR   = 1;
  localparam int unsigned NAND = 2;
  localparam int unsigned NOR  = 3;
  localparam int unsigned NOTB = 4;
  localparam int unsigned XOR  = 5;
  localparam int unsigned XNOR = 6;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCheck,
    StDone
  } state_e;

endpackage

// File: rtl/gate_golden.sv
// Combinational reference model of the gate block under test.
// Ports:
//   a, b      : gate inputs
//   expected  : 7-bit expected result, {xnor,xor,notb,nor,nand,or,and}
module gate_golden
  import gate_test_pkg::*;
(
  input  logic             a,
  input  logic             b,
  output logic [RES_W-1:0] expected
);

  always_comb begin
    expected       = '0;
    expected[AND]  = a & b;
    expected[OR]   = a | b;
    expected[NAND] = ~(a & b);
    expected[NOR]  = ~(a | b);
    expected[NOTB] = ~b;
    expected[XOR]  = a ^ b;
    expected[XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/gate_test_seq.sv
// Built-in test sequencer for a 2-input gate block. A pass walks the four
// {a,b} vectors, holds each for SETTLE_CYCLES cycles, then compares the gate
// block outputs against a golden model for one cycle and records mismatches.
//
// Parameters:
//   SETTLE_CYCLES : cycles each vector is held before sampling (1..15)
//   VEC_COUNT     : vectors per pass (fixed at 4)
// Ports:
//   clk          : clock, all state changes on rising edge
//   rst_n        : synchronous active-low reset
//   start_i      : one-cycle request to begin a pass (honoured only when idle)
//   abort_i      : cancel a running pass
//   res_i        : gate block outputs {xnor,xor,notb,nor,nand,or,and}
//   a_o, b_o     : gate input drives (current vector index while busy)
//   busy_o       : pass in progress
//   done_o       : one-cycle completion pulse
//   err_cnt_o    : saturating count of failing vectors
//   fail_mask_o  : bit k set when vector k mismatched
//   loop_i       : (only with GATE_TEST_SEQ_LOOP_EN) restart the pass from DONE
//
// Build option: define GATE_TEST_SEQ_LOOP_EN to add loop_i and continuous
// looping; fail_mask_o stays sticky and err_cnt_o keeps accumulating.
module gate_test_seq #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned VEC_COUNT     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [6:0] res_i,
`ifdef GATE_TEST_SEQ_LOOP_EN
  input  logic       loop_i,
`endif
  output logic       a_o,
  output logic       b_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] err_cnt_o,
  output logic [3:0] fail_mask_o
);

  import gate_test_pkg::*;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LastIdx    = 2'(VEC_COUNT - 1);

  state_e           state_q;
  logic [1:0]       idx_q;
  logic [3:0]       cnt_q;
  logic [RES_W-1:0] golden;
  logic             mismatch;

  gate_golden u_golden (
    .a        (idx_q[1]),
    .b        (idx_q[0]),
    .expected (golden)
  );

  assign mismatch = (res_i != golden);

  // All outputs are registered and updated together with the state so that
  // a_o/b_o/busy_o always reflect the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      a_o         <= 1'b0;
      b_o         <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_cnt_o   <= 3'd0;
      fail_mask_o <= 4'd0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q     <= StSettle;
            idx_q       <= 2'd0;
            cnt_q       <= 4'd0;
            {a_o, b_o}  <= 2'b00;
            busy_o      <= 1'b1;
            err_cnt_o   <= 3'd0;
            fail_mask_o <= 4'd0;
          end
        end

        StSettle: begin
          if (abort_i) begin
            state_q    <= StIdle;
            idx_q      <= 2'd0;
            cnt_q      <= 4'd0;
            {a_o, b_o} <= 2'b00;
            busy_o     <= 1'b0;
          end else if (cnt_q == SettleLast) begin
            state_q <= StCheck;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        StCheck: begin
          // Abort wins over the result of this cycle's comparison.
          if (abort_i) begin
            state_q    <= StIdle;
            idx_q      <= 2'd0;
            cnt_q      <= 4'd0;
            {a_o, b_o} <= 2'b00;
            busy_o     <= 1'b0;
          end else begin
            if (mismatch) begin
              fail_mask_o[idx_q] <= 1'b1;
              if (err_cnt_o != 3'd7) begin
                err_cnt_o <= err_cnt_o + 3'd1;
              end
            end
            if (idx_q == LastIdx) begin
              state_q    <= StDone;
              idx_q      <= 2'd0;
              {a_o, b_o} <= 2'b00;
              busy_o     <= 1'b0;
            end else begin
              state_q    <= StSettle;
              idx_q      <= idx_q + 2'd1;
              cnt_q      <= 4'd0;
              {a_o, b_o} <= idx_q + 2'd1;
            end
          end
        end

        StDone: begin
          done_o <= 1'b1;
`ifdef GATE_TEST_SEQ_LOOP_EN
          if (loop_i) begin
            // Results are not cleared: mask is sticky, count accumulates.
            state_q    <= StSettle;
            idx_q      <= 2'd0;
            cnt_q      <= 4'd0;
            {a_o, b_o} <= 2'b00;
            busy_o     <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
`else
          state_q <= StIdle;
`endif
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
